// File: rtl/uart_rx_monitor.sv
// UART receive monitor: oversampled deserialiser feeding a first-word-fall-through
// FIFO, with sticky parity, framing and overflow flags.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int DEPTH        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx,
  input  logic                         rd_en,
  output logic [DATA_BITS-1:0]         rd_data,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  input  logic                         clr_err,
  output logic                         parity_err,
  output logic                         frame_err,
  output logic                         overflow
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, WAIT_IDLE} state_t;

  state_t               state, state_n;
  logic                 rx_meta, rxs;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic                 sidx, sidx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 pbad, pbad_n;
  logic                 tick, push, set_perr, set_ferr;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 full, do_push, do_pop, set_ovf;

  // Two-flop synchroniser for the asynchronous serial line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receiver FSM and bit-timing datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sidx  <= 1'b0;
      shift <= '0;
      pbad  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      sidx  <= sidx_n;
      shift <= shift_n;
      pbad  <= pbad_n;
    end
  end

  // Next-state, sampling and character-acceptance decisions.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    sidx_n   = sidx;
    shift_n  = shift;
    pbad_n   = pbad;
    push     = 1'b0;
    set_perr = 1'b0;
    set_ferr = 1'b0;
    tick     = (cnt == '0);
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          cnt_n   = HALF_BIT;
        end
      end
      START: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else if (!rxs) begin
          state_n = DATA;
          cnt_n   = FULL_BIT;
          idx_n   = '0;
        end else begin
          state_n = IDLE;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          shift_n[idx] = rxs;
          cnt_n        = FULL_BIT;
          if (idx == IDX_LAST) begin
            state_n = (PARITY != 0) ? PAR : STOP;
            sidx_n  = 1'b0;
            pbad_n  = 1'b0;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      PAR: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else begin
          pbad_n  = ((^shift) ^ rxs) != ODD_PAR;
          state_n = STOP;
          cnt_n   = FULL_BIT;
          sidx_n  = 1'b0;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_n = cnt - 1'b1;
        end else if (!rxs) begin
          set_ferr = 1'b1;
          state_n  = WAIT_IDLE;
        end else if (sidx == STOP_LAST) begin
          state_n  = IDLE;
          set_perr = pbad;
          push     = !pbad;
        end else begin
          sidx_n = 1'b1;
          cnt_n  = FULL_BIT;
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign full     = (count == ($clog2(DEPTH+1))'(DEPTH));
  assign rd_valid = (wr_ptr != rd_ptr);
  assign count    = wr_ptr - rd_ptr;
  assign do_pop   = rd_en && rd_valid;
  assign do_push  = push && (!full || rd_en);
  assign set_ovf  = push && full && !rd_en;
  // When full, a simultaneous pop frees the head slot that the write pointer aliases.
  assign rd_data  = rd_valid ? mem[rd_ptr[AW-1:0]] : '0;

  // FIFO pointers; push and pop may occur together in any occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= shift;
  end

  // Sticky error flags; a set condition beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (set_perr)     parity_err <= 1'b1;
      else if (clr_err) parity_err <= 1'b0;
      if (set_ferr)     frame_err  <= 1'b1;
      else if (clr_err) frame_err  <= 1'b0;
      if (set_ovf)      overflow   <= 1'b1;
      else if (clr_err) overflow   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: 8E1, 16x oversampling, 4-entry FIFO.
module tb_uart_rx_monitor;

  localparam int CPB = 16;

  logic       clk_tb = 1'b0;
  logic       reset_tb;
  logic       rx;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] count;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk_tb = ~clk_tb;

  uart_rx_monitor #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS(8),
    .PARITY(2),
    .STOP_BITS(1),
    .DEPTH(4)
  ) dut (
    .clk(clk_tb),
    .rst(reset_tb),
    .rx(rx),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .count(count),
    .clr_err(clr_err),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one 8-bit frame with an explicit parity bit; starts and ends on a negedge.
  task automatic send_bits(input logic [7:0] d, input logic p);
    rx = 1'b0;
    repeat (CPB) @(negedge clk_tb);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk_tb);
    end
    rx = p;
    repeat (CPB) @(negedge clk_tb);
    rx = 1'b1;
    repeat (CPB) @(negedge clk_tb);
  endtask

  task automatic send(input logic [7:0] d);
    send_bits(d, ^d);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk_tb);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk_tb);
    clr_err = 1'b0;
  endtask

  initial begin
    logic [7:0] partial;
    rx       = 1'b1;
    rd_en    = 1'b0;
    clr_err  = 1'b0;
    reset_tb = 1'b1;
    repeat (3) @(negedge clk_tb);
    check("rst_count", count, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_flags", {parity_err, frame_err, overflow}, 0);
    reset_tb = 1'b0;
    repeat (4) @(negedge clk_tb);

    // 0x55: push lands exactly on the stop-sample edge (171 edges after rx falls).
    fork
      send(8'h55);
      begin
        repeat (170) @(posedge clk_tb);
        @(negedge clk_tb);
        check("pre_push_count", count, 0);
        @(negedge clk_tb);
        check("push_count", count, 1);
        check("push_valid", rd_valid, 1);
        check("push_data", rd_data, 8'h55);
      end
    join
    pop();
    check("pop_count", count, 0);
    check("pop_valid", rd_valid, 0);

    // 0xA3 with wrong (odd) parity bit.
    send_bits(8'hA3, 1'b1);
    check("perr_set", parity_err, 1);
    check("perr_count", count, 0);
    pulse_clr();
    check("perr_clr", parity_err, 0);

    // Start glitch of 4 cycles.
    rx = 1'b0;
    repeat (4) @(negedge clk_tb);
    rx = 1'b1;
    repeat (40) @(negedge clk_tb);
    check("glitch_count", count, 0);
    check("glitch_flags", {parity_err, frame_err, overflow}, 0);
    send(8'h3C);
    check("after_glitch_count", count, 1);
    check("after_glitch_data", rd_data, 8'h3C);
    pop();

    // Break of 20 bit times: one frame error, cleared mid-break must stay clear.
    rx = 1'b0;
    repeat (190) @(negedge clk_tb);
    check("break_ferr", frame_err, 1);
    check("break_count", count, 0);
    pulse_clr();
    repeat (20 * CPB - 191) @(negedge clk_tb);
    check("break_once", frame_err, 0);
    rx = 1'b1;
    repeat (32) @(negedge clk_tb);
    send(8'h0F);
    check("post_break_ferr", frame_err, 0);
    check("post_break_count", count, 1);
    check("post_break_data", rd_data, 8'h0F);
    pop();
    check("post_break_empty", count, 0);

    // Overflow: five characters into a 4-deep FIFO, no reads.
    for (int i = 1; i <= 5; i++) send(8'(i));
    check("ovf_count", count, 4);
    check("ovf_flag", overflow, 1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_pop_data", rd_data, i);
      pop();
    end
    check("ovf_drained", count, 0);
    pulse_clr();
    check("ovf_clr", overflow, 0);

    // Same, but pop on the exact cycle of the fifth push.
    for (int i = 1; i <= 4; i++) send(8'(i));
    fork
      send(8'h05);
      begin
        repeat (170) @(posedge clk_tb);
        @(negedge clk_tb);
        rd_en = 1'b1;
        @(negedge clk_tb);
        rd_en = 1'b0;
      end
    join
    check("full_pp_count", count, 4);
    check("full_pp_ovf", overflow, 0);
    for (int i = 2; i <= 5; i++) begin
      check("full_pp_data", rd_data, i);
      pop();
    end
    check("full_pp_drained", count, 0);

    // Reset mid-DATA of 0x77, with a stored entry and a sticky flag pending.
    send_bits(8'hA3, 1'b1);
    send(8'h55);
    check("pre_rst_count", count, 1);
    check("pre_rst_perr", parity_err, 1);
    partial = 8'h77;
    rx = 1'b0;
    repeat (CPB) @(negedge clk_tb);
    for (int i = 0; i < 3; i++) begin
      rx = partial[i];
      repeat (CPB) @(negedge clk_tb);
    end
    rx = 1'b1;
    reset_tb = 1'b1;
    repeat (2) @(negedge clk_tb);
    reset_tb = 1'b0;
    @(negedge clk_tb);
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_data", rd_data, 0);
    check("mid_rst_flags", {parity_err, frame_err, overflow}, 0);
    repeat (32) @(negedge clk_tb);
    send(8'h81);
    check("after_rst_count", count, 1);
    check("after_rst_data", rd_data, 8'h81);
    check("after_rst_flags", {parity_err, frame_err, overflow}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
